// File: rtl/edge_interval_capture.sv
// Times the interval between consecutive rising edges of an asynchronous input against a
// free-running 12-bit counter and buffers the intervals in a small FIFO.
module edge_interval_capture #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [11:0]                   count_in,
   input  logic                          sig_in,
   input  logic                          capture_en,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [11:0]                   out_delta,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          overflow_clr
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   edge_det;

   state_e                 state_q, state_d;
   logic [11:0]            ref_q, ref_d;
   logic                   wr_q, wr_d;
   logic [11:0]            wr_data_q, wr_data_d;

   logic [11:0]            mem_q [FIFO_DEPTH];
   logic [11:0]            mem_d [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   overflow_q, overflow_d;
   logic                   full, pop, push, drop;

   // Synchronizer plus one extra flop for rising-edge detection.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_d   = sync_q[SYNC_STAGES-1];
      edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      wr_d      = 1'b0;
      wr_data_d = wr_data_q;
      if (!capture_en) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: state_d = StArm;
            StArm: begin
               if (edge_det) begin
                  ref_d   = count_in;
                  state_d = StRun;
               end
            end
            StRun: begin
               if (edge_det) begin
                  wr_d      = 1'b1;
                  wr_data_d = count_in - ref_q;
                  ref_d     = count_in;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // The computed interval is staged one cycle before entering the FIFO.
   always_comb begin
      full       = (level_q == LW'(FIFO_DEPTH));
      pop        = out_valid & out_ready;
      push       = wr_q & (~full | pop);
      drop       = wr_q & full & ~pop;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data_q;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         state_q    <= StIdle;
         ref_q      <= '0;
         wr_q       <= 1'b0;
         wr_data_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         state_q    <= state_d;
         ref_q      <= ref_d;
         wr_q       <= wr_d;
         wr_data_q  <= wr_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         mem_q      <= mem_d;
      end
   end

   assign out_valid  = (level_q != '0);
   assign out_delta  = mem_q[rd_ptr_q];
   assign fifo_level = level_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/edge_interval_capture.md
EDGE_INTERVAL_CAPTURE -- requirements
Module: edge_interval_capture

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops on sig_in (legal 2..4).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, number of interval entries buffered (power of 2, legal 2..16).
REQ-003 SHALL provide port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port count_in  input  12  free-running 12-bit up-counter value, same clock domain.
REQ-006 SHALL provide port sig_in  input  1  asynchronous gyro pulse/sense signal to be timed.
REQ-007 SHALL provide port capture_en  input  1  1 = measure intervals; 0 = idle and discard reference.
REQ-008 SHALL provide port out_valid  output  1  FIFO head holds an interval.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL provide port out_delta  output  12  interval between consecutive rising edges, in counter ticks.
REQ-011 SHALL provide port fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently held.
REQ-012 SHALL provide port overflow  output  1  sticky; an interval was dropped because the FIFO was full.
REQ-013 SHALL provide port overflow_clr  input  1  one-cycle clear of overflow.

Function
REQ-014 SHALL pass sig_in through SYNC_STAGES flops and detect a rising edge as last-stage 1 with previous-stage-value 0 (one extra flop).
REQ-015 SHALL implement states IDLE, ARM, RUN.
REQ-016 IDLE: capture_en=1 -> ARM; detected edges ignored.
REQ-017 ARM: on detected edge, store count_in into ref register, -> RUN; no FIFO write.
REQ-018 RUN: on detected edge, compute delta = (count_in - ref) mod 4096, write delta to FIFO, load ref <= count_in in the same cycle; remain in RUN.
REQ-019 Any state: capture_en=0 -> IDLE next cycle, edge in that cycle ignored; FIFO contents retained.
REQ-020 Delta SHALL be 12-bit unsigned modular subtraction; counter wrap between edges yields correct result for intervals <4096 ticks; an interval of exactly 4096 reports 0 (documented limitation).
REQ-021 sig_in rising edge (stable ≥2 clocks) SHALL cause out_valid to rise exactly SYNC_STAGES+2 rising clock edges after first sampled high, when FIFO was empty.
REQ-022 Handshake: entry popped on cycle with out_valid=1 and out_ready=1; out_delta SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 out_delta SHALL be a registered/FIFO-array read of the head entry, FIFO order first-in first-out.
REQ-024 Write when full and no pop that cycle: entry dropped, overflow set next cycle, ref still updated.
REQ-025 Write and pop in same cycle when full: both SHALL succeed, level unchanged, overflow not set.
REQ-026 Write and pop in same cycle when empty: not possible (out_valid=0); write succeeds, level becomes 1.
REQ-027 overflow_clr and a new overflow in same cycle: overflow SHALL remain 1 (set wins).
REQ-028 fifo_level SHALL equal writes accepted minus pops, range 0..FIFO_DEPTH.

Reset
REQ-029 On reset=1 at a clock edge: state IDLE, ref=0, FIFO empty, fifo_level=0, out_valid=0, out_delta=0, overflow=0, synchronizer and edge flops 0.
REQ-030 Reset mid-operation SHALL discard all buffered entries and the reference; first edge after reset with capture_en=1 only arms.
REQ-031 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-032 capture_en=1, edges at count_in 100, 350, 1000 -> entries 250, 650; fifo_level 2; out_ready=1 drains in order.
REQ-033 Edges at count_in 4000 then 200 (wrapped) -> out_delta 296.
REQ-034 FIFO_DEPTH=4, out_ready=0, six edges -> 5 intervals; 4 stored, 5th dropped, overflow=1; overflow_clr pulse -> overflow=0.
REQ-035 FIFO full, edge coincident with pop -> fifo_level stays 4, overflow stays 0, new entry at tail.
REQ-036 Edges at 100, 300; capture_en low 1 cycle; edges at 500, 900 -> entries 200, 400 only (500 re-arms).
REQ-037 Reset asserted with 3 entries held -> next cycle out_valid=0, fifo_level=0, overflow=0, state IDLE.
